// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronizes and debounces channels A/B, then decodes clean
// edges into single-cycle step pulses, a direction flag and a wrapping 4-bit position.
module quad_step_decoder #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       clr,
  input  logic       err_clr,
  output logic       step,
  output logic       dir,
  output logic [3:0] pos,
  output logic       err,
  output logic       err_flag
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e state_q, state_d;
  logic   in_init;

  logic [8:0] init_cnt_q, init_cnt_d;

  // Bit 1 carries channel A, bit 0 channel B, so {f[1], f[0]} reads as AB.
  logic [1:0]      s1_q, s2_q;
  logic [1:0]      f_q, f_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      prev_q, prev_d;

  logic       step_q, step_d;
  logic       dir_q, dir_d;
  logic [3:0] pos_q, pos_d;
  logic       err_q, err_d;
  logic       err_flag_q, err_flag_d;

  // Position of an AB code along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      init_cnt_d = init_cnt_q + 9'd1;
      if (init_cnt_q == 9'(FILT_LEN + 1)) begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    in_init = (state_q == StInit);
  end

  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (in_init) begin
        f_d[i]   = s2_q[i];
        cnt_d[i] = '0;
      end else if (s2_q[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == 8'(FILT_LEN - 1)) begin
        f_d[i]   = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    step_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    prev_d     = prev_q;
    pos_d      = pos_q;
    err_flag_d = err_flag_q;

    // Track the filter during startup so the levels present at release never decode.
    if (in_init) begin
      prev_d = s2_q;
    end else if (f_q != prev_q) begin
      prev_d = f_q;
      if ((f_q ^ prev_q) == 2'b11) begin
        err_d = 1'b1;
      end else begin
        step_d = 1'b1;
        dir_d  = (phase(f_q) == phase(prev_q) + 2'd1);
      end
    end

    if (clr) begin
      pos_d = '0;
    end else if (step_d) begin
      pos_d = dir_d ? pos_q + 4'd1 : pos_q - 4'd1;
    end

    if (err_d) begin
      err_flag_d = 1'b1;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      f_q        <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      pos_q      <= '0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      s1_q       <= {a, b};
      s2_q       <= s1_q;
      f_q        <= f_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign pos      = pos_q;
  assign err      = err_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILT_LEN = 4: startup, counting, wrap,
// glitch rejection, illegal transitions, clear priority and asynchronous reset.
module tb_quad_step_decoder;

  localparam int unsigned FILT_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n, a, b, clr, err_clr;
  logic       step, dir, err, err_flag;
  logic [3:0] pos;

  int total = 0;
  int bad   = 0;
  int n_step, n_err, n_dir0, n_dir1;
  logic first_dir;
  int cur_phase;

  quad_step_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .clr      (clr),
    .err_clr  (err_clr),
    .step     (step),
    .dir      (dir),
    .pos      (pos),
    .err      (err),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) begin
      if (n_step == 0) first_dir = dir;
      n_step++;
      if (dir === 1'b1) n_dir1++;
      else n_dir0++;
    end
    if (err === 1'b1) n_err++;
  endtask

  task automatic clear_counts();
    n_step = 0; n_err = 0; n_dir0 = 0; n_dir1 = 0; first_dir = 1'bx;
  endtask

  task automatic set_phase(input int p);
    a = (p == 1 || p == 2);
    b = (p == 2 || p == 3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    cur_phase = 0;
    clear_counts();
  endtask

  task automatic move(input int n, input bit up);
    for (int i = 0; i < n; i++) begin
      cur_phase = up ? (cur_phase + 1) % 4 : (cur_phase + 3) % 4;
      set_phase(cur_phase);
      repeat (8) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 1'b1; b = 1'b1; clr = 1'b0; err_clr = 1'b0;
    clear_counts();
    repeat (3) tick();
    total++;
    if (step !== 1'b0 || dir !== 1'b1 || pos !== 4'd0 || err !== 1'b0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: step=%b dir=%b pos=%0d err=%b flag=%b, need 0 1 0 0 0",
               step, dir, pos, err, err_flag);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (step !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL startup_quiet cycle %0d: step=%b err=%b, need 0 0", i, step, err);
      end
    end
    total++;
    if (pos !== 4'd0 || dir !== 1'b1) begin
      bad++;
      $display("FAIL startup_state: pos=%0d dir=%b, need 0 1", pos, dir);
    end
  endtask

  task automatic test_up_count();
    do_reset();
    cur_phase = 1;
    set_phase(cur_phase);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) begin
        total++;
        if (step !== 1'b0) begin
          bad++;
          $display("FAIL latency_early: step=%b at cycle 6, need 0", step);
        end
      end
      if (k == 7) begin
        total++;
        if (step !== 1'b1 || dir !== 1'b1 || pos !== 4'd1) begin
          bad++;
          $display("FAIL latency_step: step=%b dir=%b pos=%0d, need 1 1 1", step, dir, pos);
        end
      end
    end
    move(3, 1'b1);
    total++;
    if (n_step != 4 || n_dir1 != 4 || pos !== 4'd4) begin
      bad++;
      $display("FAIL up_count: steps=%0d up=%0d pos=%0d, need 4 4 4", n_step, n_dir1, pos);
    end
  endtask

  task automatic test_wrap_down();
    do_reset();
    move(17, 1'b1);
    total++;
    if (n_step != 17 || pos !== 4'd1) begin
      bad++;
      $display("FAIL wrap_up: steps=%0d pos=%0d, need 17 1", n_step, pos);
    end
    clear_counts();
    move(2, 1'b0);
    total++;
    if (n_step != 2 || n_dir0 != 2 || pos !== 4'd15 || dir !== 1'b0) begin
      bad++;
      $display("FAIL wrap_down: steps=%0d down=%0d pos=%0d dir=%b, need 2 2 15 0",
               n_step, n_dir0, pos, dir);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    a = 1'b1;
    repeat (3) tick();
    a = 1'b0;
    repeat (12) tick();
    total++;
    if (n_step != 0 || n_err != 0 || pos !== 4'd0) begin
      bad++;
      $display("FAIL glitch_3: steps=%0d errs=%0d pos=%0d, need 0 0 0", n_step, n_err, pos);
    end
    clear_counts();
    a = 1'b1;
    repeat (4) tick();
    a = 1'b0;
    repeat (16) tick();
    total++;
    if (n_step != 2 || first_dir !== 1'b1 || n_dir0 != 1 || pos !== 4'd0) begin
      bad++;
      $display("FAIL glitch_4: steps=%0d first_dir=%b downs=%0d pos=%0d, need 2 1 1 0",
               n_step, first_dir, n_dir0, pos);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    a = 1'b1; b = 1'b1;
    repeat (12) tick();
    total++;
    if (n_err != 1 || n_step != 0 || err_flag !== 1'b1 || pos !== 4'd0 || dir !== 1'b1) begin
      bad++;
      $display("FAIL illegal: errs=%0d steps=%0d flag=%b pos=%0d dir=%b, need 1 0 1 0 1",
               n_err, n_step, err_flag, pos, dir);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err_flag !== 1'b0) begin
      bad++;
      $display("FAIL err_clr_alone: flag=%b, need 0", err_flag);
    end
    a = 1'b0; b = 1'b0;
    repeat (6) tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_early: err=%b, need 0", err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b1 || err_flag !== 1'b1) begin
      bad++;
      $display("FAIL err_vs_clr: err=%b flag=%b, need 1 1", err, err_flag);
    end
    tick();
    total++;
    if (err !== 1'b0 || err_flag !== 1'b1) begin
      bad++;
      $display("FAIL err_pulse_width: err=%b flag=%b, need 0 1", err, err_flag);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    move(7, 1'b1);
    total++;
    if (pos !== 4'd7) begin
      bad++;
      $display("FAIL pos_seven: pos=%0d, need 7", pos);
    end
    cur_phase = (cur_phase + 1) % 4;
    set_phase(cur_phase);
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (step !== 1'b1 || pos !== 4'd0) begin
      bad++;
      $display("FAIL clr_vs_step: step=%b pos=%0d, need 1 0", step, pos);
    end
    tick();
    total++;
    if (pos !== 4'd0) begin
      bad++;
      $display("FAIL clr_hold: pos=%0d, need 0", pos);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    move(2, 1'b1);
    move(1, 1'b0);
    total++;
    if (pos !== 4'd1 || dir !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset: pos=%0d dir=%b, need 1 0", pos, dir);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if (pos !== 4'd0 || dir !== 1'b1 || step !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: pos=%0d dir=%b step=%b, need 0 1 0", pos, dir, step);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (15) tick();
    total++;
    if (n_step != 0 || n_err != 0 || pos !== 4'd0) begin
      bad++;
      $display("FAIL reset_release_quiet: steps=%0d errs=%0d pos=%0d, need 0 0 0",
               n_step, n_err, pos);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap_down();
    test_glitch();
    test_illegal();
    test_clear_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
